// File: rtl/ps2_key_event_fifo.sv
// ps2_key_event_fifo
//   Turns PS/2 Set-2 scan-code frames into 10-bit key events.
//   It runs the E0/F0 prefix state machine and queues the events in a
//   first-word-fall-through FIFO.
// Ports:
//   Clock50   - system clock, rising edge
//   iReset    - synchronous active-low reset
//   iValid    - one-cycle frame strobe qualifying iKey/iError
//   iKey      - decoded scan-code byte
//   iError    - decoder parity/framing error for this frame
//   iRead     - pop head event (ignored while empty)
//   oEvent    - head event {extended, release, code}; holds last value when empty
//   oEmpty    - FIFO empty (registered)
//   oFull     - FIFO holds DEPTH events (registered)
//   oOverflow - sticky: an event was dropped on a full FIFO
//   oErrCnt   - saturating count of rejected frames and protocol errors
module ps2_key_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ERRW  = 4
) (
  input  logic            Clock50,
  input  logic            iReset,
  input  logic            iValid,
  input  logic [7:0]      iKey,
  input  logic            iError,
  input  logic            iRead,
  output logic [9:0]      oEvent,
  output logic            oEmpty,
  output logic            oFull,
  output logic            oOverflow,
  output logic [ERRW-1:0] oErrCnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

  state_t        state, stateNext;
  logic          push, errInc;
  logic [9:0]    newEvent;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr, rdNext;
  logic [CW-1:0] count, countNext;
  logic          doPop, doPush;
  logic [9:0]    headNext;

  // Prefix state machine: decides whether this frame produces an event
  always_comb begin
    stateNext = state;
    push      = 1'b0;
    errInc    = 1'b0;
    newEvent  = {2'b00, iKey};
    if (iValid) begin
      if (iError || iKey == 8'h00 || iKey == 8'hFF) begin
        errInc    = 1'b1;
        stateNext = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (iKey == 8'hE0)      stateNext = EXT;
            else if (iKey == 8'hF0) stateNext = BRK;
            else begin
              push     = 1'b1;
              newEvent = {2'b00, iKey};
            end
          end
          EXT: begin
            if (iKey == 8'hE0)      stateNext = EXT;
            else if (iKey == 8'hF0) stateNext = EXTBRK;
            else begin
              push      = 1'b1;
              newEvent  = {2'b10, iKey};
              stateNext = IDLE;
            end
          end
          BRK: begin
            stateNext = IDLE;
            if (iKey == 8'hE0 || iKey == 8'hF0) errInc = 1'b1;
            else begin
              push     = 1'b1;
              newEvent = {2'b01, iKey};
            end
          end
          EXTBRK: begin
            stateNext = IDLE;
            if (iKey == 8'hE0 || iKey == 8'hF0) errInc = 1'b1;
            else begin
              push     = 1'b1;
              newEvent = {2'b11, iKey};
            end
          end
          default: stateNext = IDLE;
        endcase
      end
    end
  end

  // FIFO control. A pop while full frees the slot the push writes into.
  always_comb begin
    doPop     = iRead && (count != '0);
    doPush    = push && ((count != CW'(DEPTH)) || doPop);
    rdNext    = rdPtr + AW'(doPop);
    countNext = count + CW'(doPush) - CW'(doPop);
    // Head comes straight from the incoming event when it lands in the head slot
    headNext  = (doPush && rdNext == wrPtr) ? newEvent : mem[rdNext];
  end

  always_ff @(posedge Clock50) begin
    if (doPush) mem[wrPtr] <= newEvent;
  end

  always_ff @(posedge Clock50) begin
    if (!iReset) begin
      state     <= IDLE;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      oEvent    <= '0;
      oEmpty    <= 1'b1;
      oFull     <= 1'b0;
      oOverflow <= 1'b0;
      oErrCnt   <= '0;
    end else begin
      state  <= stateNext;
      rdPtr  <= rdNext;
      count  <= countNext;
      oEmpty <= (countNext == '0);
      oFull  <= (countNext == CW'(DEPTH));
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (countNext != '0) oEvent <= headNext;
      if (push && !doPush) oOverflow <= 1'b1;
      if (errInc && oErrCnt != '1) oErrCnt <= oErrCnt + ERRW'(1);
    end
  end

endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
- Sits directly downstream of the PS/2 frame decoder and consumes its per-frame scan-code byte and its parity/framing error flag.
- Runs the PS/2 Set-2 prefix state machine: E0 marks an extended key, F0 marks a break (release) code.
- Produces one 10-bit key event per completed key transition and buffers events in a first-word-fall-through FIFO for the consumer (display/controller logic).

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
ERRW, 4, width of the saturating error counter.

Ports:
Clock50  input  1  system clock, 50 MHz, all logic on rising edge.
iReset  input  1  synchronous, active-low reset; sampled on Clock50 rising edge.
iValid  input  1  one-cycle strobe: a decoded frame is present on iKey/iError.
iKey  input  8  decoded scan-code byte; qualified by iValid.
iError  input  1  decoder parity/framing error for this frame; qualified by iValid.
iRead  input  1  consumer pops the head event; ignored while oEmpty=1.
oEvent  output  10  head event: [9]=extended, [8]=release, [7:0]=scan code.
oEmpty  output  1  FIFO holds no events.
oFull  output  1  FIFO holds DEPTH events.
oOverflow  output  1  sticky flag: an event was dropped because the FIFO was full.
oErrCnt  output  ERRW  saturating count of rejected frames and protocol errors.

Behaviour:
- Reset (iReset=0 at a clock edge):
  - state=IDLE, FIFO emptied.
  - oEmpty=1, oFull=0, oOverflow=0, oErrCnt=0, oEvent=0.
  - Reset overrides all inputs in that cycle, including a partial E0/F0 sequence.
- Frames are processed only in cycles with iValid=1. iKey and iError are don't-care otherwise.
- Error frames: if iError=1, discard the frame, increment oErrCnt (saturates at all-ones), state→IDLE.
- Junk codes: iKey=8'h00 or 8'hFF (keyboard overrun) are treated as errors in every state: increment oErrCnt, state→IDLE, no push.
- Prefix FSM (valid, error-free frames):
  - IDLE: E0→EXT; F0→BRK; any other code→push {0,0,code}, stay IDLE.
  - EXT: E0→stay EXT; F0→EXTBRK; other→push {1,0,code}, →IDLE.
  - BRK: E0 or F0→protocol error (oErrCnt+1), →IDLE, no push; other→push {0,1,code}, →IDLE.
  - EXTBRK: E0 or F0→protocol error, →IDLE; other→push {1,1,code}, →IDLE.
- Latency: a push is written at the same clock edge that samples iValid. On the following cycle oEmpty=0 and, if the FIFO was empty, oEvent equals the new event.
- FIFO (first-word-fall-through):
  - oEvent always shows the head entry.
  - iRead=1 with oEmpty=0 advances the head at the clock edge.
  - When the FIFO goes empty, oEvent holds its last value; consumers must qualify it with oEmpty.
- Boundary conditions:
  - Push while full with no pop: event dropped, oOverflow←1 (held until reset), contents unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow, occupancy stays DEPTH.
  - Push and pop in the same cycle while empty: push only (pop ignored).
  - Push and pop in the same cycle otherwise: occupancy unchanged, order preserved.
  - Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits. oFull = (count==DEPTH), oEmpty = (count==0); both are registered.

Test Plan:
- Reset: hold iReset=0 for 3 cycles with iValid toggling → oEmpty=1, oFull=0, oOverflow=0, oErrCnt=0, oEvent=0; no push occurs.
- Plain key: frames 1C, F0, 1C, each a 1-cycle iValid spaced 8000 cycles apart → FIFO holds 0x01C then 0x11C. Pop with iRead → oEvent shows 0x01C then 0x11C, then oEmpty=1.
- Extended key: frames E0,75 then E0,F0,75 → events 0x275 then 0x375. Frame E0,E0,75 → single event 0x275.
- Errors: frame 16 with iError=1 → no push, oErrCnt=1. Sequence F0,E0,16 → one protocol error (oErrCnt=2) then push 0x016. Frame FF → oErrCnt=3. 20 error frames → oErrCnt saturates at 15.
- Full/overflow: push 9 make codes 01..09 with DEPTH=8, no reads → oFull=1 after the 8th, 9th dropped, oOverflow=1, pops return 01..08 in order. Then push and pop in the same cycle while full → occupancy stays 8, oOverflow stays 1.
- Reset mid-sequence: send E0,F0, then pulse iReset low, then frame 75 → single event 0x075 (prefix state cleared).
